// File: rtl/acc_cpu_core.sv
// acc_cpu_core
//   Parametrised accumulator-style CPU that executes one instruction per clock.
//   Instructions are fetched via an external port. The core has a register file,
//   zero and carry flags, conditional jumps, an output register with a valid
//   strobe, and a HALT state that a resume request can leave without a reset.
//
// Ports
//   inclk      in   1        clock, all state changes on rising edge
//   rst_n      in   1        asynchronous active-low reset
//   instr_addr out  PC_W     fetch address (the program counter)
//   instr_data in   INSTR_W  instruction word at instr_addr, {op|rd|rs|imm}
//   in_data    in   DATA_W   input port, read by IN
//   resume     in   1        leave HALT (only looked at while halted)
//   out_data   out  DATA_W   output register, written by OUT
//   out_valid  out  1        high for the one cycle after an OUT executes
//   halted     out  1        high while in HALT
//   zf, cf     out  1        zero and carry flags
module acc_cpu_core #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int PC_W   = 4,
  localparam int RS_W    = $clog2(NREG),
  localparam int INSTR_W = 4 + 2*RS_W + DATA_W
) (
  input  logic               inclk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               resume,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               halted,
  output logic               zf,
  output logic               cf
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_IN   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JNZ  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic {
    st_run,
    st_halt
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next, pc_plus1, jmp_target;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        op;
  logic [RS_W-1:0]   rd, rs;
  logic [DATA_W-1:0] imm, rd_val, rs_val, operand;
  logic [DATA_W:0]   add_sum, sub_diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, reg_we, flag_we, exec;

  assign op     = instr_data[INSTR_W-1 -: 4];
  assign rd     = instr_data[DATA_W+RS_W +: RS_W];
  assign rs     = instr_data[DATA_W +: RS_W];
  assign imm    = instr_data[DATA_W-1:0];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];

  assign exec       = (state == st_run);
  assign halted     = (state == st_halt);
  assign instr_addr = pc;
  assign pc_plus1   = pc + PC_W'(1);

  // Jump target is the low PC_W bits of imm, zero-extended when the program
  // space is wider than the immediate.
  generate
    if (PC_W <= DATA_W) begin : g_tgt_trunc
      assign jmp_target = imm[PC_W-1:0];
    end else begin : g_tgt_ext
      assign jmp_target = {{(PC_W-DATA_W){1'b0}}, imm};
    end
  endgenerate

  // One extra bit on each side gives carry-out for add and borrow for sub.
  assign operand  = (op == OP_ADDI) ? imm : rs_val;
  assign add_sum  = {1'b0, rd_val} + {1'b0, operand};
  assign sub_diff = {1'b0, rd_val} - {1'b0, rs_val};

  // Datapath decode: the value to write back to R[rd] and the new carry.
  // Only ops 3-8 touch the flags; everything else leaves them alone.
  always_comb begin
    alu_res = rd_val;
    alu_c   = cf;
    reg_we  = 1'b0;
    flag_we = 1'b0;
    case (op)
      OP_MOVI: begin alu_res = imm;     reg_we = 1'b1; end
      OP_MOV:  begin alu_res = rs_val;  reg_we = 1'b1; end
      OP_IN:   begin alu_res = in_data; reg_we = 1'b1; end
      OP_ADD, OP_ADDI: begin
        {alu_c, alu_res} = add_sum;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUB: begin
        {alu_c, alu_res} = sub_diff;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin alu_res = rd_val & rs_val; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      OP_OR:  begin alu_res = rd_val | rs_val; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      OP_XOR: begin alu_res = rd_val ^ rs_val; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      default: ;
    endcase
  end

  // Sequencing: pc advance, jumps (tested against the current flags), and the
  // RUN/HALT transitions. HLT keeps pc on its own address; resume steps past it.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      st_run: begin
        pc_next = pc_plus1;
        case (op)
          OP_JMP: pc_next = jmp_target;
          OP_JZ:  if (zf)  pc_next = jmp_target;
          OP_JC:  if (cf)  pc_next = jmp_target;
          OP_JNZ: if (!zf) pc_next = jmp_target;
          OP_HLT: begin
            state_next = st_halt;
            pc_next    = pc;
          end
          default: ;
        endcase
      end
      st_halt: begin
        if (resume) begin
          state_next = st_run;
          pc_next    = pc_plus1;
        end
      end
      default: begin
        state_next = st_run;
        pc_next    = '0;
      end
    endcase
  end

  // Control state: FSM state and program counter.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= st_run;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Architectural state: register file, flags and output port. Nothing here
  // changes while halted, and out_valid drops to 0 in that case.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= exec && (op == OP_OUT);
      if (exec && reg_we) regs[rd] <= alu_res;
      if (exec && flag_we) begin
        zf <= (alu_res == '0);
        cf <= alu_c;
      end
      if (exec && (op == OP_OUT)) out_data <= rs_val;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core
//   Directed test of acc_cpu_core with DATA_W=8, NREG=4, PC_W=4. Programs are
//   held in a small array that feeds instr_data from instr_addr; expected values
//   are worked out by hand for each program.
module tb_acc_cpu_core;

  localparam int DATA_W  = 8;
  localparam int NREG    = 4;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;

  localparam logic [3:0] NOP = 4'h0, MOVI = 4'h1, MOV = 4'h2, ADD = 4'h3;
  localparam logic [3:0] ADDI = 4'h4, SUB = 4'h5, AND = 4'h6, OR = 4'h7;
  localparam logic [3:0] XOR = 4'h8, IN = 4'h9, OUT = 4'hA, JMP = 4'hB;
  localparam logic [3:0] JZ = 4'hC, JC = 4'hD, JNZ = 4'hE, HLT = 4'hF;

  logic               inclk;
  logic               rst_n;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic [DATA_W-1:0]  in_data;
  logic               resume;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               halted;
  logic               zf, cf;

  logic [INSTR_W-1:0] prog [16];
  logic               use_rand;
  logic [INSTR_W-1:0] rand_word;
  int                 num_checks;
  int                 num_fails;

  acc_cpu_core #(
    .DATA_W(DATA_W),
    .NREG  (NREG),
    .PC_W  (PC_W)
  ) dut (
    .inclk     (inclk),
    .rst_n     (rst_n),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .in_data   (in_data),
    .resume    (resume),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .zf        (zf),
    .cf        (cf)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  assign instr_data = use_rand ? rand_word : prog[instr_addr];

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                             input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 16; i++) prog[i] = enc(NOP, 2'd0, 2'd0, 8'h00);
  endtask

  // Advance a number of clock edges and settle just after the last one.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge inclk);
      #1;
      if (use_rand) rand_word = INSTR_W'($urandom);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    rst_n      = 1'b0;
    resume     = 1'b0;
    in_data    = '0;
    use_rand   = 1'b0;
    rand_word  = '0;
    clearProg();

    // Preload registers and flags with nonzero values, then halt.
    prog[0] = enc(MOVI, 2'd0, 2'd0, 8'h11);
    prog[1] = enc(MOVI, 2'd1, 2'd0, 8'h22);
    prog[2] = enc(MOVI, 2'd2, 2'd0, 8'h33);
    prog[3] = enc(MOVI, 2'd3, 2'd0, 8'h44);
    prog[4] = enc(ADDI, 2'd3, 2'd0, 8'hFF);
    prog[5] = enc(OUT,  2'd0, 2'd3, 8'h00);
    prog[6] = enc(HLT,  2'd0, 2'd0, 8'h00);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(6);
    checkOutput("pre_out_data", 32'(out_data), 32'h43);
    checkOutput("pre_out_valid", 32'(out_valid), 32'h1);
    checkOutput("pre_cf", 32'(cf), 32'h1);
    checkOutput("pre_zf", 32'(zf), 32'h0);
    applyStimulus(1);
    checkOutput("pre_halted", 32'(halted), 32'h1);

    // Reset with random instruction words on the fetch port.
    rst_n     = 1'b0;
    use_rand  = 1'b1;
    rand_word = INSTR_W'($urandom);
    #1;
    checkOutput("rst_async_halted", 32'(halted), 32'h0);
    applyStimulus(2);
    checkOutput("rst_pc", 32'(instr_addr), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_zf", 32'(zf), 32'h0);
    checkOutput("rst_cf", 32'(cf), 32'h0);

    // Every register reads back zero, then a MOV round trip.
    clearProg();
    prog[0] = enc(OUT,  2'd0, 2'd0, 8'h00);
    prog[1] = enc(OUT,  2'd0, 2'd1, 8'h00);
    prog[2] = enc(OUT,  2'd0, 2'd2, 8'h00);
    prog[3] = enc(OUT,  2'd0, 2'd3, 8'h00);
    prog[4] = enc(MOVI, 2'd0, 2'd0, 8'h5A);
    prog[5] = enc(MOV,  2'd3, 2'd0, 8'h00);
    prog[6] = enc(OUT,  2'd0, 2'd3, 8'h00);
    use_rand = 1'b0;
    rst_n    = 1'b1;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1);
      checkOutput($sformatf("rst_reg%0d", r), 32'(out_data), 32'h0);
      checkOutput($sformatf("rst_reg%0d_valid", r), 32'(out_valid), 32'h1);
    end
    applyStimulus(3);
    checkOutput("mov_out", 32'(out_data), 32'h5A);

    // Arithmetic flags and conditional jumps.
    rst_n = 1'b0;
    applyStimulus(1);
    clearProg();
    prog[0]  = enc(MOVI, 2'd0, 2'd0, 8'hF0);
    prog[1]  = enc(ADDI, 2'd0, 2'd0, 8'h20);
    prog[2]  = enc(OUT,  2'd0, 2'd0, 8'h00);
    prog[3]  = enc(SUB,  2'd0, 2'd0, 8'h00);
    prog[4]  = enc(JZ,   2'd0, 2'd0, 8'h08);
    prog[8]  = enc(JNZ,  2'd0, 2'd0, 8'h02);
    prog[9]  = enc(OUT,  2'd0, 2'd0, 8'h00);
    prog[10] = enc(MOVI, 2'd1, 2'd0, 8'h01);
    prog[11] = enc(MOVI, 2'd2, 2'd0, 8'h02);
    prog[12] = enc(SUB,  2'd1, 2'd2, 8'h00);
    prog[13] = enc(OUT,  2'd0, 2'd1, 8'h00);
    prog[14] = enc(JC,   2'd0, 2'd0, 8'h03);
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("addi_cf", 32'(cf), 32'h1);
    checkOutput("addi_zf", 32'(zf), 32'h0);
    applyStimulus(1);
    checkOutput("addi_result", 32'(out_data), 32'h10);
    applyStimulus(1);
    checkOutput("sub_zf", 32'(zf), 32'h1);
    checkOutput("sub_cf", 32'(cf), 32'h0);
    applyStimulus(1);
    checkOutput("jz_taken_pc", 32'(instr_addr), 32'h8);
    applyStimulus(1);
    checkOutput("jnz_not_taken_pc", 32'(instr_addr), 32'h9);
    applyStimulus(1);
    checkOutput("sub_result", 32'(out_data), 32'h0);
    applyStimulus(3);
    checkOutput("borrow_cf", 32'(cf), 32'h1);
    checkOutput("borrow_zf", 32'(zf), 32'h0);
    applyStimulus(1);
    checkOutput("borrow_result", 32'(out_data), 32'hFF);
    applyStimulus(1);
    checkOutput("jc_taken_pc", 32'(instr_addr), 32'h3);

    // IN/OUT, logic ops, HALT/resume, back-to-back OUT, pc wrap.
    rst_n = 1'b0;
    applyStimulus(1);
    clearProg();
    prog[0]  = enc(IN,   2'd1, 2'd0, 8'h00);
    prog[1]  = enc(OUT,  2'd0, 2'd1, 8'h00);
    prog[2]  = enc(MOVI, 2'd2, 2'd0, 8'hF0);
    prog[3]  = enc(ADDI, 2'd2, 2'd0, 8'h1F);
    prog[4]  = enc(AND,  2'd2, 2'd1, 8'h00);
    prog[5]  = enc(OUT,  2'd0, 2'd2, 8'h00);
    prog[6]  = enc(HLT,  2'd0, 2'd0, 8'h00);
    prog[7]  = enc(XOR,  2'd1, 2'd1, 8'h00);
    prog[8]  = enc(OUT,  2'd0, 2'd1, 8'h00);
    prog[9]  = enc(OUT,  2'd0, 2'd2, 8'h00);
    prog[10] = enc(JMP,  2'd0, 2'd0, 8'h0E);
    in_data = 8'hA5;
    rst_n   = 1'b1;
    applyStimulus(2);
    checkOutput("in_out_data", 32'(out_data), 32'hA5);
    checkOutput("in_out_valid", 32'(out_valid), 32'h1);
    applyStimulus(1);
    checkOutput("out_valid_pulse_end", 32'(out_valid), 32'h0);
    checkOutput("out_data_held", 32'(out_data), 32'hA5);
    applyStimulus(1);
    checkOutput("addi2_cf", 32'(cf), 32'h1);
    applyStimulus(1);
    checkOutput("and_cf_cleared", 32'(cf), 32'h0);
    checkOutput("and_zf", 32'(zf), 32'h0);
    applyStimulus(1);
    checkOutput("and_result", 32'(out_data), 32'h05);
    applyStimulus(1);
    checkOutput("hlt_halted", 32'(halted), 32'h1);
    checkOutput("hlt_pc", 32'(instr_addr), 32'h6);
    checkOutput("hlt_out_valid", 32'(out_valid), 32'h0);
    in_data = 8'h3C;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("halt_hold_pc_%0d", c), 32'(instr_addr), 32'h6);
      checkOutput($sformatf("halt_hold_flag_%0d", c), 32'(halted), 32'h1);
    end
    resume = 1'b1;
    applyStimulus(1);
    checkOutput("resume_pc", 32'(instr_addr), 32'h7);
    checkOutput("resume_halted", 32'(halted), 32'h0);
    applyStimulus(1);
    checkOutput("resume_ignored_pc", 32'(instr_addr), 32'h8);
    checkOutput("xor_zf", 32'(zf), 32'h1);
    resume = 1'b0;
    applyStimulus(1);
    checkOutput("b2b_out1_data", 32'(out_data), 32'h00);
    checkOutput("b2b_out1_valid", 32'(out_valid), 32'h1);
    applyStimulus(1);
    checkOutput("b2b_out2_data", 32'(out_data), 32'h05);
    checkOutput("b2b_out2_valid", 32'(out_valid), 32'h1);
    applyStimulus(1);
    checkOutput("jmp_pc", 32'(instr_addr), 32'hE);
    applyStimulus(1);
    checkOutput("nop_pc15", 32'(instr_addr), 32'hF);
    applyStimulus(1);
    checkOutput("wrap_pc0", 32'(instr_addr), 32'h0);
    applyStimulus(7);
    checkOutput("halt_again", 32'(halted), 32'h1);
    checkOutput("halt_again_out", 32'(out_data), 32'h0C);

    // Reset while halted.
    rst_n = 1'b0;
    #1;
    checkOutput("halt_rst_halted", 32'(halted), 32'h0);
    checkOutput("halt_rst_pc", 32'(instr_addr), 32'h0);
    checkOutput("halt_rst_out_data", 32'(out_data), 32'h0);
    checkOutput("halt_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("halt_rst_zf", 32'(zf), 32'h0);
    checkOutput("halt_rst_cf", 32'(cf), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
